demux1x2_buf: RTL
=================

// Module: demux1x2_buf
// PURPOSE
//  Buffered 1-to-2 demultiplexer: the receive-side counterpart of the 2x1 mux.
//  Accepts one input stream under a valid/ready handshake and steers each word
//  to output lane 0 or lane 1 according to select s0.
//  Each lane has its own small FIFO and a ready/valid handshake, so a stalled
//  lane never blocks traffic for the other lane.
//  Sits between a shared (time-multiplexed) link and two independent consumers.
// PARAMETERS
//  WIDTH  8  data width of I, y0, y1
//  DEPTH  2  entries per lane FIFO; power of two, >= 2
//  CNTW   8  width of the per-lane accepted-word counters cnt0/cnt1
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  I         in   WIDTH  input data word
//  s0        in   1      lane select: 0 -> lane 0, 1 -> lane 1; sampled with I
//  in_valid  in   1      I and s0 are valid this cycle
//  in_ready  out  1      block can accept I this cycle
//  y0        out  WIDTH  lane 0 head-of-FIFO data
//  y0_valid  out  1      lane 0 holds at least one word
//  y0_ready  in   1      lane 0 consumer takes y0 this cycle
//  y1        out  WIDTH  lane 1 head-of-FIFO data
//  y1_valid  out  1      lane 1 holds at least one word
//  y1_ready  in   1      lane 1 consumer takes y1 this cycle
//  cnt0      out  CNTW   words accepted into lane 0, modulo 2^CNTW
//  cnt1      out  CNTW   words accepted into lane 1, modulo 2^CNTW
// BEHAVIOUR
//  Reset (rst_n low, asynchronous)
//   - Both FIFOs are emptied and all pointers cleared.
//   - y0=y1=0, y0_valid=y1_valid=0, cnt0=cnt1=0.
//   - in_ready=0 while rst_n is low; in_ready=1 from the first clk edge after release.
//   - Reset asserted mid-transfer discards all buffered words; nothing is replayed.
//  Input handshake
//   - in_ready = !full[s0]. It is a combinational function of s0 and the lane state.
//   - There is no combinational path from y0_ready/y1_ready to in_ready.
//   - A word is accepted on a clk edge where in_valid && in_ready.
//   - On acceptance: I is pushed into the FIFO of lane s0, and cnt<s0> increments.
//   - Counters wrap from 2^CNTW-1 to 0.
//   - Only the selected lane is written; the other lane is never touched.
//  Output handshake (per lane k)
//   - yk_valid = !empty_k.
//   - yk shows the head word; yk = 0 when the lane is empty.
//   - A pop occurs on a clk edge where yk_valid && yk_ready.
//   - yk and yk_valid stay stable while yk_ready=0.
//  Latency
//   - A word accepted at edge n is visible on yk / yk_valid after edge n (one cycle).
//   - There is no same-cycle bypass from I to yk.
//  FIFO occupancy
//   - Each lane tracks occupancy 0..DEPTH using wrap-around read/write pointers of
//     log2(DEPTH) bits plus one extra wrap bit.
//   - full  = pointers equal except the wrap bit.
//   - empty = pointers identical.
//  Simultaneous events
//   - Push and pop on the same lane in one cycle: occupancy is unchanged and data
//     order is preserved. This applies only when the lane is not full, since a full
//     lane has in_ready=0.
//   - Push to one lane with a pop from the other lane: both take effect independently.
//   - Full lane with a pop this cycle: in_ready is still 0 this cycle and returns to 1
//     the next cycle.
//  Ordering and loss
//   - Words within a lane leave in arrival order.
//   - No word is dropped or duplicated.
//   - in_valid while in_ready=0 has no effect on any state.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> y0/y1_valid=0,
//     cnt0=cnt1=0, in_ready=0; release -> in_ready=1.
//  2. Routing: I=8'hA5, s0=0, one valid cycle -> next cycle y0=A5, y0_valid=1,
//     y1_valid=0, cnt0=1, cnt1=0. Repeat with I=8'h3C, s0=1 -> appears on y1 only.
//  3. Backpressure: y1_ready=0, push 11,22 to lane 1 -> in_ready=0 when s0=1,
//     in_ready=1 when s0=0; push 33 to lane 0 -> y0=33.
//     Set y1_ready=1 -> y1 emits 11 then 22.
//  4. Concurrent push/pop: lane 0 holds 1 word with y0_ready=1, push 8'h77 to lane 0
//     every cycle for 6 cycles -> occupancy stays at 1, in_ready stays 1, and y0
//     sequence matches the pushes.
//  5. Counter wrap: push 256 words to lane 0 with y0_ready=1 -> cnt0 goes 255 -> 0,
//     cnt1 stays 0.
//  6. Reset mid-operation: both lanes full, pulse rst_n low asynchronously between
//     clock edges -> outputs clear immediately; after release no stale word appears.

Source files
------------

// File: rtl/demux1x2_buf_if.sv
// Handshake bundle for the buffered 1-to-2 demultiplexer: one input stream, two output lanes.
// The slave modport is the demux itself; the master modport is the surrounding link/consumers.
interface demux1x2_buf_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 8
);
  logic [WIDTH-1:0] I;
  logic             s0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport master (
    output I, s0, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );

  modport slave (
    input  I, s0, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 demultiplexer: each accepted word is pushed into the FIFO of lane s0,
// and each lane drains independently under its own valid/ready handshake.
module demux1x2_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 8
) (
  input logic           clk,
  input logic           rst_n,
  demux1x2_buf_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             armed;
  logic             in_ready;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       y_ready;
  logic [WIDTH-1:0] head [2];

  assign y_ready  = {bus.y1_ready, bus.y0_ready};
  // Depends only on s0 and registered lane state, never on the lane ready inputs.
  assign in_ready = armed & ~full[bus.s0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             sel;
    logic             push;
    logic             pop;

    assign sel      = (k == 0) ? ~bus.s0 : bus.s0;
    assign push     = bus.in_valid & in_ready & sel;
    assign pop      = ~empty[k] & y_ready[k];
    assign full[k]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty[k] = (wr_ptr == rd_ptr);
    assign head[k]  = empty[k] ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end

    // Storage needs no reset: an empty lane masks its head to zero.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.I;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y0       = head[0];
  assign bus.y1       = head[1];
  assign bus.y0_valid = ~empty[0];
  assign bus.y1_valid = ~empty[1];
  assign bus.cnt0     = g_lane[0].cnt;
  assign bus.cnt1     = g_lane[1].cnt;
endmodule
